frame_load_ctrl: RTL and testbench
==================================

Name: frame_load_ctrl

Overview:
- Sequences loading of 8-bit pixel frames from the UART receiver into the dual-port image BRAM.
- Each frame is a 2-byte sync header followed by exactly IMG_PIXELS bytes. The block hunts for the header, then generates sequential write addresses and write strobes.
- It double-buffers two BRAM banks: the completed bank is handed to the VGA read side only during vertical blanking, so a partial frame is never displayed.
- Sits between uart_rx and ram_2port, and drives the bank-select MSB of both BRAM ports.

Parameters:
- IMG_PIXELS, 307200, pixel bytes per frame (640x480).
- ADDR_W, 19, width of in-bank pixel address.
- SYNC0, 8'hAA, first header byte.
- SYNC1, 8'h55, second header byte.
- TIMEOUT_CYC, 5000000, inter-byte idle limit in clk cycles (100 ms at 50 MHz).

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from uart_rx.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- rx_frame_error  in  1  qualifies rx_valid; byte had a bad stop bit.
- vblank  in  1  high during VGA vertical blanking (synchronous to clk).
- err_clr  in  1  one-cycle pulse, clears sticky error flags.
- wr_en  out  1  BRAM write strobe.
- wr_addr  out  ADDR_W  in-bank write address.
- wr_data  out  8  BRAM write data.
- wr_bank  out  1  bank being written (BRAM write address MSB).
- rd_bank  out  1  bank being displayed (BRAM read address MSB).
- busy  out  1  high in SYNC1_WAIT, LOAD or SWAP_WAIT.
- frame_done  out  1  one-cycle pulse on bank swap.
- frame_count  out  8  completed-frame counter.
- err_frame  out  1  sticky: frame aborted by a stop-bit error.
- err_timeout  out  1  sticky: frame aborted by idle timeout.

Behaviour:
- Reset values: state IDLE, wr_en 0, wr_addr 0, wr_data 0, wr_bank 1, rd_bank 0, busy 0, frame_done 0, frame_count 0, both error flags 0, timer 0. Reset mid-frame discards the partial frame and restores the bank mapping.
- Good byte: rx_valid=1 and rx_frame_error=0. A byte with rx_frame_error=1 is never written.
- IDLE: good byte equal to SYNC0 -> SYNC1_WAIT. All other bytes are ignored.
- SYNC1_WAIT:
  - good SYNC1 -> LOAD, with pixel index cleared to 0.
  - good SYNC0 -> stay in SYNC1_WAIT.
  - any other good byte, or an errored byte -> IDLE, with no error flag set.
- LOAD, good byte:
  - Exactly one cycle later: wr_en=1 for one cycle, wr_data=byte, wr_addr=current index. The index then increments.
  - The byte written at index IMG_PIXELS-1 moves the state to SWAP_WAIT, and the index wraps to 0.
- LOAD, errored byte: set err_frame, go to IDLE, no write. Bank mapping is unchanged; the displayed bank remains intact.
- Timeout:
  - The timer is cleared on any rx_valid and on entry to SYNC1_WAIT or LOAD. It counts in SYNC1_WAIT and LOAD only.
  - On reaching TIMEOUT_CYC-1: go to IDLE. Set err_timeout only if the state was LOAD.
  - If rx_valid and timeout occur in the same cycle, rx_valid wins and the timer clears.
- SWAP_WAIT:
  - Incoming bytes are dropped, including SYNC0 (no header hunting).
  - On the first cycle with vblank=1: rd_bank<=wr_bank, wr_bank<=~wr_bank, frame_done=1 for that cycle, frame_count+1 (wraps 255->0), then go to IDLE.
  - The earliest swap is the cycle after SWAP_WAIT is entered. vblank being high when the last write occurs does not count as the swap cycle.
- Invariant: wr_bank and rd_bank always differ.
- Error flags stay set until err_clr or rst. If err_clr and a new error event occur in the same cycle, the set wins.
- busy is registered and reflects the current state.

Decomposition:
- Package frame_load_pkg holds:
  - state enum {IDLE, SYNC1_WAIT, LOAD, SWAP_WAIT}
  - default constants IMG_PIXELS, SYNC0, SYNC1, TIMEOUT_CYC
  - ADDR_W derived as clog2(IMG_PIXELS)
- One sub-module, frame_idle_timer: a clearable up-counter with a terminal-count pulse, parameterised by TIMEOUT_CYC.
- The state machine, address counter and bank logic stay in frame_load_ctrl.

Test Plan (IMG_PIXELS=16, TIMEOUT_CYC=200):
- Nominal frame: send AA 55 00..0F, vblank pulse 50 cycles later.
  - 16 writes at addr 0..15 with data 00..0F, each one cycle after its rx_valid.
  - frame_done at the vblank cycle; wr_bank 1->0, rd_bank 0->1, frame_count=1.
- Header hunt: send 12 AA AA 55 07.
  - No write for 12/AA/AA/55.
  - First write is addr 0, data 07.
- Stop-bit error: send AA 55, 5 good bytes, then a byte with rx_frame_error=1.
  - No 6th write, err_frame=1, state IDLE, banks unchanged.
  - err_clr then clears err_frame to 0.
- Timeout: send AA 55 and 3 bytes, then idle 200 cycles.
  - err_timeout=1, busy=0.
  - Next AA 55 + 16 bytes completes normally starting at addr 0.
- Swap hold-off: complete a frame with vblank held low 1000 cycles while sending AA 55 01.
  - No writes, no frame_done, busy=1.
  - Raising vblank gives exactly one frame_done pulse.
- Reset mid-LOAD: assert rst after 8 pixels.
  - All outputs return to reset values next cycle (wr_bank=1, rd_bank=0, frame_count=0).
  - A new full frame then loads from addr 0.

Source files
------------

// File: rtl/frame_load_pkg.sv
// Shared types and default constants for the frame loader.
package frame_load_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SYNC1_WAIT,
        LOAD,
        SWAP_WAIT
    } state_e;

    localparam int unsigned IMG_PIXELS_DEF  = 307200;
    localparam int unsigned ADDR_W_DEF      = $clog2(IMG_PIXELS_DEF);
    localparam logic [7:0]  SYNC0_DEF       = 8'hAA;
    localparam logic [7:0]  SYNC1_DEF       = 8'h55;
    localparam int unsigned TIMEOUT_CYC_DEF = 5000000;

    // Loader is busy whenever it is not hunting for a header.
    function automatic logic state_busy(state_e s);
        return s != IDLE;
    endfunction

endpackage

// File: rtl/frame_idle_timer.sv
// Clearable idle counter; tc flags the last cycle of the idle window.
module frame_idle_timer #(
    parameter int unsigned TIMEOUT_CYC = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tc = en && (cnt_q == LAST);

    // Next count: clear has priority, otherwise count only while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/frame_load_ctrl.sv
// Hunts for the sync header, writes frame pixels into the back BRAM bank and
// swaps banks during vertical blanking.
module frame_load_ctrl
    import frame_load_pkg::*;
#(
    parameter int unsigned IMG_PIXELS  = IMG_PIXELS_DEF,
    parameter int unsigned ADDR_W      = $clog2(IMG_PIXELS),
    parameter logic [7:0]  SYNC0       = SYNC0_DEF,
    parameter logic [7:0]  SYNC1       = SYNC1_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rx_frame_error,
    input  logic              vblank,
    input  logic              err_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              busy,
    output logic              frame_done,
    output logic [7:0]        frame_count,
    output logic              err_frame,
    output logic              err_timeout
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_PIXELS - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              rd_bank_q, rd_bank_d;
    logic              busy_q, busy_d;
    logic              frame_done_q, frame_done_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic              err_frame_q, err_frame_d;
    logic              err_timeout_q, err_timeout_d;

    logic good_byte;
    logic bad_byte;
    logic timer_en;
    logic timer_clr;
    logic timer_tc;
    logic timed_out;
    logic set_err_frame;
    logic set_err_timeout;

    assign good_byte = rx_valid && !rx_frame_error;
    assign bad_byte  = rx_valid && rx_frame_error;
    assign timer_en  = (state_q == SYNC1_WAIT) || (state_q == LOAD);
    // Every state entry that restarts the idle window comes with rx_valid.
    assign timer_clr = rx_valid || timer_tc;
    // A byte arriving on the terminal cycle keeps the frame alive.
    assign timed_out = timer_tc && !rx_valid;

    frame_idle_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_idle_timer (
        .clk(clk),
        .rst(rst),
        .clr(timer_clr),
        .en (timer_en),
        .tc (timer_tc)
    );

    // Next-state, write-port and bank/flag logic.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        wr_en_d         = 1'b0;
        wr_addr_d       = wr_addr_q;
        wr_data_d       = wr_data_q;
        rd_bank_d       = rd_bank_q;
        frame_done_d    = 1'b0;
        frame_count_d   = frame_count_q;
        set_err_frame   = 1'b0;
        set_err_timeout = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (good_byte && rx_data == SYNC0) begin
                    state_d = SYNC1_WAIT;
                end
            end
            SYNC1_WAIT: begin
                if (good_byte) begin
                    if (rx_data == SYNC1) begin
                        state_d = LOAD;
                        idx_d   = '0;
                    end else if (rx_data != SYNC0) begin
                        state_d = IDLE;
                    end
                end else if (bad_byte || timed_out) begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (good_byte) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = idx_q;
                    wr_data_d = rx_data;
                    if (idx_q == LAST_IDX) begin
                        state_d = SWAP_WAIT;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_W'(1);
                    end
                end else if (bad_byte) begin
                    set_err_frame = 1'b1;
                    state_d       = IDLE;
                end else if (timed_out) begin
                    set_err_timeout = 1'b1;
                    state_d         = IDLE;
                end
            end
            SWAP_WAIT: begin
                // Bytes are dropped here; only vblank moves us on.
                if (vblank) begin
                    rd_bank_d     = ~rd_bank_q;
                    frame_done_d  = 1'b1;
                    frame_count_d = frame_count_q + 8'd1;
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Set beats clear when both land in the same cycle.
        err_frame_d   = set_err_frame   ? 1'b1 : (err_clr ? 1'b0 : err_frame_q);
        err_timeout_d = set_err_timeout ? 1'b1 : (err_clr ? 1'b0 : err_timeout_q);
        busy_d        = state_busy(state_d);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            rd_bank_q     <= 1'b0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            err_frame_q   <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            rd_bank_q     <= rd_bank_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            frame_count_q <= frame_count_d;
            err_frame_q   <= err_frame_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    // Write bank is derived from the read bank so the two can never collide.
    assign rd_bank     = rd_bank_q;
    assign wr_bank     = ~rd_bank_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frame_count = frame_count_q;
    assign err_frame   = err_frame_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Directed and randomized stimulus for frame_load_ctrl against a byte-level model.
module tb_frame_load_ctrl;

    localparam int unsigned N  = 16;
    localparam int unsigned AW = 4;
    localparam int unsigned T  = 200;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_frame_error;
    logic          vblank;
    logic          err_clr;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_bank;
    logic          rd_bank;
    logic          busy;
    logic          frame_done;
    logic [7:0]    frame_count;
    logic          err_frame;
    logic          err_timeout;

    always #5 clk = ~clk;

    frame_load_ctrl #(
        .IMG_PIXELS (N),
        .ADDR_W     (AW),
        .SYNC0      (8'hAA),
        .SYNC1      (8'h55),
        .TIMEOUT_CYC(T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_frame_error(rx_frame_error),
        .vblank        (vblank),
        .err_clr       (err_clr),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_bank       (wr_bank),
        .rd_bank       (rd_bank),
        .busy          (busy),
        .frame_done    (frame_done),
        .frame_count   (frame_count),
        .err_frame     (err_frame),
        .err_timeout   (err_timeout)
    );

    int checks   = 0;
    int failures = 0;

    // Model: phase 0 hunting, 1 saw SYNC0, 2 loading pixels, 3 frame complete.
    int unsigned m_phase;
    int unsigned m_idx;
    int unsigned m_quiet;
    int unsigned m_count;
    bit          m_rd;
    bit          m_errf;
    bit          m_errt;
    bit          m_we;
    bit          m_done;
    int unsigned m_addr;
    int unsigned m_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_idx = 0; m_quiet = 0; m_count = 0;
        m_rd = 0; m_errf = 0; m_errt = 0; m_we = 0; m_done = 0;
    endtask

    // One clock of the reference model, evaluated on the inputs seen at that edge.
    task automatic model_cycle(input bit v, input logic [7:0] d, input bit fe,
                               input bit vb, input bit clr);
        bit good;
        bit bad;
        bit tmo;
        bit setf;
        bit sett;
        good = v && !fe;
        bad  = v && fe;
        setf = 0;
        sett = 0;
        m_we = 0;
        m_done = 0;
        // Idle window: T consecutive byte-less cycles while hunting SYNC1 or loading.
        tmo = 0;
        if (m_phase == 1 || m_phase == 2) begin
            if (!v) begin
                if (m_quiet == T - 1) tmo = 1;
                else m_quiet++;
            end
        end
        if (v || tmo) m_quiet = 0;

        case (m_phase)
            0: if (good && d == 8'hAA) m_phase = 1;
            1: begin
                if (good) begin
                    if (d == 8'h55) begin
                        m_phase = 2;
                        m_idx = 0;
                    end else if (d != 8'hAA) begin
                        m_phase = 0;
                    end
                end else if (bad || tmo) begin
                    m_phase = 0;
                end
            end
            2: begin
                if (good) begin
                    m_we = 1;
                    m_addr = m_idx;
                    m_data = d;
                    m_idx++;
                    if (m_idx == N) begin
                        m_idx = 0;
                        m_phase = 3;
                    end
                end else if (bad) begin
                    setf = 1;
                    m_phase = 0;
                end else if (tmo) begin
                    sett = 1;
                    m_phase = 0;
                end
            end
            default: begin
                if (vb) begin
                    m_rd = !m_rd;
                    m_done = 1;
                    m_count = (m_count + 1) % 256;
                    m_phase = 0;
                end
            end
        endcase
        m_errf = setf ? 1'b1 : (clr ? 1'b0 : m_errf);
        m_errt = sett ? 1'b1 : (clr ? 1'b0 : m_errt);
    endtask

    task automatic check_outputs();
        chk("wr_en", wr_en, m_we);
        if (m_we) begin
            chk("wr_addr", wr_addr, m_addr);
            chk("wr_data", wr_data, m_data);
        end
        chk("wr_bank", wr_bank, !m_rd);
        chk("rd_bank", rd_bank, m_rd);
        chk("bank_distinct", wr_bank ^ rd_bank, 1);
        chk("busy", busy, m_phase != 0);
        chk("frame_done", frame_done, m_done);
        chk("frame_count", frame_count, m_count);
        chk("err_frame", err_frame, m_errf);
        chk("err_timeout", err_timeout, m_errt);
    endtask

    // Drive one clock of inputs (called just after a falling edge), then check.
    task automatic step(input bit v, input logic [7:0] d, input bit fe, input bit vb,
                        input bit clr);
        rx_valid = v;
        rx_data = d;
        rx_frame_error = fe;
        vblank = vb;
        err_clr = clr;
        model_cycle(v, d, fe, vb, clr);
        @(negedge clk);
        rx_valid = 1'b0;
        rx_frame_error = 1'b0;
        err_clr = 1'b0;
        check_outputs();
    endtask

    task automatic send(input logic [7:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input bit vb);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, vb, 1'b0);
    endtask

    // Header plus N random pixels with short random gaps, vblank low.
    task automatic send_frame();
        send(8'hAA);
        send(8'h55);
        for (int i = 0; i < int'(N); i++) begin
            send(8'($urandom));
            idle(int'($urandom_range(0, 2)), 1'b0);
        end
    endtask

    task automatic swap();
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_frame_error = 1'b0;
        err_clr = 1'b0;
        vblank = 1'b0;
        rx_data = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs();
        chk("reset_wr_addr", wr_addr, 0);
        chk("reset_wr_data", wr_data, 0);
    endtask

    initial begin
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_frame_error = 1'b0;
        rx_data = 8'h00;
        vblank = 1'b0;
        err_clr = 1'b0;
        do_reset();

        // Nominal frame with pixels 00..0F, vblank 50 cycles later.
        send(8'hAA);
        send(8'h55);
        for (int i = 0; i < int'(N); i++) send(8'(i));
        idle(50, 1'b0);
        idle(1, 1'b1);
        idle(2, 1'b0);

        // Header hunt: 12 AA AA 55 07 ...
        send(8'h12);
        send(8'hAA);
        send(8'hAA);
        send(8'h55);
        send(8'h07);
        for (int i = 1; i < int'(N); i++) send(8'($urandom));
        swap();

        // Stop-bit error after 5 pixels, then clear the flag.
        send(8'hAA);
        send(8'h55);
        for (int i = 0; i < 5; i++) send(8'($urandom));
        step(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0);
        idle(2, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        // Error and clear on the same cycle: the error must stick.
        send(8'hAA);
        send(8'h55);
        send(8'h11);
        step(1'b1, 8'h22, 1'b1, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Timeout in LOAD, then a clean frame from address 0.
        send(8'hAA);
        send(8'h55);
        for (int i = 0; i < 3; i++) send(8'($urandom));
        idle(int'(T) + 5, 1'b0);
        send_frame();
        swap();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

        // Timeout while waiting for SYNC1 leaves no flag behind.
        send(8'hAA);
        idle(int'(T) + 3, 1'b0);

        // Byte arriving on the last idle cycle keeps the frame going.
        send(8'hAA);
        send(8'h55);
        idle(int'(T) - 1, 1'b0);
        for (int i = 0; i < int'(N); i++) send(8'($urandom));
        swap();

        // Swap hold-off: long vblank-low wait with header bytes that must be dropped.
        send_frame();
        idle(300, 1'b0);
        send(8'hAA);
        send(8'h55);
        send(8'h01);
        idle(697, 1'b0);
        idle(5, 1'b1);
        idle(2, 1'b0);

        // vblank already high on the last write does not swap that same cycle.
        send(8'hAA);
        send(8'h55);
        for (int i = 0; i < int'(N) - 1; i++) send(8'($urandom));
        step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0);
        idle(3, 1'b1);
        idle(2, 1'b0);

        // Reset mid-LOAD after 8 pixels, then a full frame from address 0.
        send(8'hAA);
        send(8'h55);
        for (int i = 0; i < 8; i++) send(8'($urandom));
        do_reset();
        send_frame();
        swap();

        // Random byte stream biased toward header bytes.
        for (int i = 0; i < 4000; i++) begin
            bit          v;
            bit          fe;
            bit          vb;
            bit          clr;
            logic [7:0]  d;
            int unsigned r;
            v = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 3);
            d = (r == 0) ? 8'hAA : (r == 1) ? 8'h55 : 8'($urandom);
            fe = ($urandom_range(0, 39) == 0);
            vb = ($urandom_range(0, 29) == 0);
            clr = ($urandom_range(0, 99) == 0);
            step(v, d, fe, vb, clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
